timing_loop_filter: RTL and testbench
=====================================

// Module: timing_loop_filter
// PURPOSE
// - Proportional-integral loop filter for symbol-timing recovery.
// - Sits directly downstream of the Gardner TED and takes its once-per-symbol error words.
// - Produces a saturated timing-control word for the interpolator/NCO. That NCO generates
//   the TED trigger, which closes the loop.
// PARAMETERS
// - ErrLengthBits        25  width of signed TED error input
// - IntegratorLengthBits 32  width of signed integrator register (>= ErrLengthBits)
// - OutputLengthBits     16  width of signed control-word output
// - KpShift               8  proportional gain = 2^-KpShift (arithmetic right shift)
// - KiShift              16  integral gain = 2^-KiShift (must be >= KpShift)
// - LockThreshold       256  |err| at or below this counts as "in lock" (macro only)
// - LockCount            32  consecutive in-lock errors before lock asserts (macro only)
// PORTS
// - clk        in   1                     clock
// - rst        in   1                     synchronous reset, active-high
// - err        in   ErrLengthBits         signed TED error
// - err_valid  in   1                     err presented
// - err_ready  out  1                     block can accept err this cycle
// - freeze     in   1                     hold integrator (proportional path still active)
// - out        out  OutputLengthBits      signed control word
// - out_valid  out  1                     out holds a new word
// - out_ready  in   1                     downstream accepts out
// - lock       out  1                     loop-locked flag (present only with macro)
// BEHAVIOUR
// - One clock (clk). Reset is synchronous and active-high on rst; rst wins over all other inputs.
// - Reset values: integrator=0, out=0, out_valid=0, lock=0, lock counter=0.
// - Handshake rules
//   - Accept occurs when err_valid && err_ready.
//   - err_ready = !out_valid || out_ready (combinational, single output register).
// - Arithmetic on accept
//   - p = err >>> KpShift; i_inc = err >>> KiShift. Truncation is toward -inf; no rounding.
//   - integ_next = sat_I(integ + i_inc) if !freeze, else integ.
//   - sat_I clamps to the two's-complement min/max of IntegratorLengthBits; it never wraps.
//   - integ <= integ_next. The sum is computed at IntegratorLengthBits+1 bits before clamping.
//   - out <= sat_O(p + integ_next), clamped to the OutputLengthBits range.
//   - out_valid <= 1.
// - Latency: one cycle. The accepted err appears on out at the next clk edge.
// - Output hold: out_valid && !out_ready holds out/out_valid stable. No err is accepted, and
//   the integrator does not move.
// - Drain: out_valid && out_ready with no accept clears out_valid to 0. out keeps its last value.
// - Simultaneous events
//   - Accept and drain in the same cycle leave out_valid at 1 with the new word (full throughput).
//   - freeze sampled only on accept cycles; toggling freeze between words has no effect.
// - Reset mid-operation: any pending out word is discarded. The integrator clears, and the
//   next accepted err is treated as the first.
// CONFIGURATION
// - Macro TIMING_LOOP_FILTER_LOCK_DETECT_EN.
// - Defined
//   - Port lock exists and a lock counter of $clog2(LockCount+1) bits is built.
//   - Each accept with |err| <= LockThreshold increments the counter, saturating at LockCount.
//   - Each accept with |err| > LockThreshold clears the counter.
//   - lock is registered, = (counter == LockCount).
//   - |most-negative err| is treated as > LockThreshold.
// - Undefined: the lock port and counter are absent. All other behaviour is identical.
// STRUCTURE
// - timing_loop_filter_pkg
//   - Saturation-limit constants.
//   - Function sat_clamp(value, width) shared with the interpolator NCO.
// - Sub-module timing_loop_filter_sat_add: a signed adder with parametric widths and
//   saturating output. Instanced twice: integrator update and P+I sum.
// - Top level holds the handshake, registers and lock logic.
// TESTING
// - All tests use KpShift=4, KiShift=8.
// - Basic: reset, then accept err=4096 twice -> out=272 then 288; integ=16 then 32.
// - Negative truncation: from reset, err=-1 -> out=-2 (p=-1, i_inc=-1); integ=-1.
// - Backpressure
//   - Hold out_ready=0 for 5 cycles with err_valid=1 -> out_valid=1, err_ready=0.
//   - out and integ stay stable; release -> next word is accepted the same cycle.
// - Saturation
//   - Set IntegratorLengthBits=16 and drive err=+max repeatedly.
//   - Integ clamps at 32767, never wraps negative; out clamps at 32767.
// - Freeze: accept err=4096 (integ=16), then freeze=1 and err=4096 -> out=272, integ stays 16.
// - Lock (macro on, LockCount=4)
//   - 4 accepts of err=100 -> lock=1 after the 4th.
//   - err=1000 -> lock=0; mid-run rst -> lock=0, out_valid=0.

Source files
------------

// File: rtl/timing_loop_filter_pkg.sv
// Shared saturation helpers for the timing-recovery loop filter and interpolator NCO.
package timing_loop_filter_pkg;

  localparam int SatCalcBits = 64;

  typedef logic signed [SatCalcBits-1:0] sat_word_t;

  function automatic sat_word_t sat_max(input int width);
    return (sat_word_t'(1) <<< (width - 1)) - sat_word_t'(1);
  endfunction

  function automatic sat_word_t sat_min(input int width);
    return -sat_max(width) - sat_word_t'(1);
  endfunction

  // Clamp a wide signed value into the two's-complement range of 'width' bits.
  function automatic sat_word_t sat_clamp(input sat_word_t value, input int width);
    sat_word_t hi;
    sat_word_t lo;
    hi = sat_max(width);
    lo = sat_min(width);
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/timing_loop_filter_sat_add.sv
// Signed adder with one guard bit and a saturating output of arbitrary width.
module timing_loop_filter_sat_add #(
  parameter int AWidth = 32,
  parameter int BWidth = 25,
  parameter int YWidth = 32
) (
  input  logic signed [AWidth-1:0] a,
  input  logic signed [BWidth-1:0] b,
  output logic signed [YWidth-1:0] y
);
  import timing_loop_filter_pkg::*;

  localparam int SumWidth = ((AWidth > BWidth) ? AWidth : BWidth) + 1;

  logic signed [SumWidth-1:0] sum;

  assign sum = SumWidth'(a) + SumWidth'(b);
  assign y   = YWidth'(sat_clamp(sat_word_t'(sum), YWidth));

endmodule

// File: rtl/timing_loop_filter.sv
// PI loop filter for symbol-timing recovery; optional lock detector built when
// TIMING_LOOP_FILTER_LOCK_DETECT_EN is defined.
module timing_loop_filter #(
  parameter int ErrLengthBits        = 25,
  parameter int IntegratorLengthBits = 32,
  parameter int OutputLengthBits     = 16,
  parameter int KpShift              = 8,
  parameter int KiShift              = 16
`ifdef TIMING_LOOP_FILTER_LOCK_DETECT_EN
  ,
  parameter int LockThreshold        = 256,
  parameter int LockCount            = 32
`endif
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic signed [ErrLengthBits-1:0]    err,
  input  logic                               err_valid,
  output logic                               err_ready,
  input  logic                               freeze,
  output logic signed [OutputLengthBits-1:0] out,
  output logic                               out_valid,
  input  logic                               out_ready
`ifdef TIMING_LOOP_FILTER_LOCK_DETECT_EN
  ,
  output logic                               lock
`endif
);
  import timing_loop_filter_pkg::*;

  // Handshake: a word moves on any edge where valid && ready. The single output
  // register frees up whenever it is empty or being drained in the same cycle.
  logic accept;
  assign err_ready = !out_valid || out_ready;
  assign accept    = err_valid && err_ready;

  logic signed [IntegratorLengthBits-1:0] integ;
  logic signed [IntegratorLengthBits-1:0] integ_sum;
  logic signed [IntegratorLengthBits-1:0] integ_next;
  logic signed [ErrLengthBits-1:0]        p_term;
  logic signed [ErrLengthBits-1:0]        i_inc;
  logic signed [OutputLengthBits-1:0]     out_next;

  assign p_term = err >>> KpShift;
  assign i_inc  = err >>> KiShift;

  timing_loop_filter_sat_add #(
    .AWidth(IntegratorLengthBits),
    .BWidth(ErrLengthBits),
    .YWidth(IntegratorLengthBits)
  ) u_integ_add (
    .a(integ),
    .b(i_inc),
    .y(integ_sum)
  );

  assign integ_next = freeze ? integ : integ_sum;

  timing_loop_filter_sat_add #(
    .AWidth(ErrLengthBits),
    .BWidth(IntegratorLengthBits),
    .YWidth(OutputLengthBits)
  ) u_out_add (
    .a(p_term),
    .b(integ_next),
    .y(out_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      integ     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      integ     <= integ_next;
      out       <= out_next;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef TIMING_LOOP_FILTER_LOCK_DETECT_EN
  localparam int LockCntBits = $clog2(LockCount + 1);

  logic signed [ErrLengthBits:0] err_wide;
  logic signed [ErrLengthBits:0] err_mag;
  logic                          err_is_min;
  logic                          err_small;
  logic [LockCntBits-1:0]        lock_cnt;
  logic [LockCntBits-1:0]        lock_cnt_next;

  assign err_wide   = (ErrLengthBits + 1)'(err);
  assign err_mag    = (err_wide < 0) ? -err_wide : err_wide;
  // The most-negative error has no representable magnitude; never call it small.
  assign err_is_min = err[ErrLengthBits-1] && (err[ErrLengthBits-2:0] == '0);
  assign err_small  = !err_is_min && (err_mag <= (ErrLengthBits + 1)'(LockThreshold));

  always_comb begin
    lock_cnt_next = '0;
    if (err_small) begin
      lock_cnt_next = (lock_cnt == LockCntBits'(LockCount)) ? lock_cnt
                                                            : lock_cnt + LockCntBits'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt <= '0;
      lock     <= 1'b0;
    end else if (accept) begin
      lock_cnt <= lock_cnt_next;
      lock     <= (lock_cnt_next == LockCntBits'(LockCount));
    end
  end
`endif

endmodule

// File: tb/tb_timing_loop_filter.sv
// Randomized scoreboard bench for timing_loop_filter (16-bit err/integ/out, Kp=4, Ki=8).
module tb_timing_loop_filter;

  localparam int EW = 16;
  localparam int IW = 16;
  localparam int OW = 16;
  localparam int KP = 4;
  localparam int KI = 8;
  localparam int LTHR = 256;
  localparam int LCNT = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [EW-1:0] err = '0;
  logic                 err_valid = 1'b0;
  logic                 err_ready;
  logic                 freeze = 1'b0;
  logic signed [OW-1:0] out;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
`ifdef TIMING_LOOP_FILTER_LOCK_DETECT_EN
  logic                 lock;
`endif

  timing_loop_filter #(
    .ErrLengthBits(EW),
    .IntegratorLengthBits(IW),
    .OutputLengthBits(OW),
    .KpShift(KP),
    .KiShift(KI)
`ifdef TIMING_LOOP_FILTER_LOCK_DETECT_EN
    ,
    .LockThreshold(LTHR),
    .LockCount(LCNT)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .err(err),
    .err_valid(err_valid),
    .err_ready(err_ready),
    .freeze(freeze),
    .out(out),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef TIMING_LOOP_FILTER_LOCK_DETECT_EN
    ,
    .lock(lock)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: held low

  // Scoreboard entry: {lock, integ[15:0], out[15:0]}
  logic [32:0] exp_q[$];

  // Reference model state
  int m_integ = 0;
  int m_cnt   = 0;
  int m_last_out = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int floor_shift(input int a, input int sh);
    int d;
    int q;
    d = 1 << sh;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int clamp(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_accept(input int e, input bit f);
    int p;
    int ii;
    int o;
    int mag;
    bit lk;
    p  = floor_shift(e, KP);
    ii = floor_shift(e, KI);
    if (!f) m_integ = clamp(m_integ + ii, IW);
    o = clamp(p + m_integ, OW);
    mag = (e < 0) ? -e : e;
    if (e != -(1 << (EW - 1)) && mag <= LTHR) m_cnt = (m_cnt < LCNT) ? m_cnt + 1 : LCNT;
    else m_cnt = 0;
    lk = (m_cnt == LCNT);
    m_last_out = o;
    exp_q.push_back({lk, 16'(m_integ), 16'(o)});
  endtask

  // out_ready driver
  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare every word as it leaves the output register
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_out", int'(out), int'($signed(e[15:0])));
          check("sb_integ", int'(dut.integ), int'($signed(e[31:16])));
`ifdef TIMING_LOOP_FILTER_LOCK_DETECT_EN
          check("sb_lock", int'(lock), int'(e[32]));
`endif
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    err_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    m_integ = 0;
    m_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic send(input int e, input bit f);
    int guard;
    @(negedge clk);
    err = EW'(e);
    freeze = f;
    err_valid = 1'b1;
    #1;
    guard = 0;
    while (!err_ready && guard < 1000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!err_ready) begin
      check("send_timeout", 0, 1);
    end else begin
      model_accept(e, f);
    end
    @(posedge clk);
    #1;
    err_valid = 1'b0;
    freeze = 1'($urandom_range(0, 1));
  endtask

  task automatic expect_now(input string name, input int exp_out, input int exp_integ);
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_out"}, int'(out), exp_out);
    check({name, "_integ"}, int'(dut.integ), exp_integ);
  endtask

  task automatic drain();
    int guard;
    ready_mode = 0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int held_out;
    int held_integ;
    int e;
    ready_mode = 0;
    do_reset();
    #1;
    check("rst_out", int'(out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_err_ready", int'(err_ready), 1);
    check("rst_integ", int'(dut.integ), 0);
`ifdef TIMING_LOOP_FILTER_LOCK_DETECT_EN
    check("rst_lock", int'(lock), 0);
`endif

    // Basic
    send(4096, 1'b0);
    expect_now("basic1", 272, 16);
    send(4096, 1'b0);
    expect_now("basic2", 288, 32);
    drain();

    // Negative truncation
    do_reset();
    send(-1, 1'b0);
    expect_now("neg", -2, -1);
    drain();

    // Freeze
    do_reset();
    send(4096, 1'b0);
    expect_now("frz1", 272, 16);
    send(4096, 1'b1);
    expect_now("frz2", 272, 16);
    drain();

    // Backpressure
    do_reset();
    ready_mode = 2;
    send(4096, 1'b0);
    held_out = m_last_out;
    held_integ = m_integ;
    @(negedge clk);
    err = EW'(8192);
    freeze = 1'b0;
    err_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_err_ready", int'(err_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out", int'(out), held_out);
      check("bp_integ", int'(dut.integ), held_integ);
      @(negedge clk);
    end
    ready_mode = 0;
    @(negedge clk);
    #1;
    check("bp_release_ready", int'(err_ready), 1);
    model_accept(8192, 1'b0);
    @(posedge clk);
    #1;
    err_valid = 1'b0;
    expect_now("bp_next", m_last_out, m_integ);
    drain();

    // Saturation
    do_reset();
    for (int k = 0; k < 300; k++) send(32767, 1'b0);
    expect_now("sat", 32767, 32767);
    for (int k = 0; k < 10; k++) send(-32768, 1'b0);
    drain();
    do_reset();
    for (int k = 0; k < 300; k++) send(-32768, 1'b0);
    expect_now("sat_neg", -32768, -32768);
    drain();

`ifdef TIMING_LOOP_FILTER_LOCK_DETECT_EN
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send(100, 1'b0);
      check("lock_early", int'(lock), 0);
    end
    send(100, 1'b0);
    check("lock_set", int'(lock), 1);
    send(1000, 1'b0);
    check("lock_clear", int'(lock), 0);
    for (int k = 0; k < 5; k++) send(-256, 1'b0);
    check("lock_neg_edge", int'(lock), 1);
    send(-32768, 1'b0);
    check("lock_min_err", int'(lock), 0);
    drain();
`endif

    // Mid-run reset discards pending word
    ready_mode = 2;
    send(4096, 1'b0);
    do_reset();
    ready_mode = 0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
`ifdef TIMING_LOOP_FILTER_LOCK_DETECT_EN
    check("midrst_lock", int'(lock), 0);
`endif
    send(4096, 1'b0);
    expect_now("midrst_first", 272, 16);
    drain();

    // Randomized traffic with random backpressure and freeze
    do_reset();
    ready_mode = 1;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0: e = $urandom_range(0, 512) - 256;
        1: e = $urandom_range(0, 65535) - 32768;
        2: e = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
        default: e = $urandom_range(0, 8191) - 4096;
      endcase
      send(e, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
